uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among NUM_REQ requesters (status reporter, command-response path, debug echo of received bytes, etc.).
- Round-robin arbitration with packet lock: once granted, a requester keeps the transmitter until it sends a byte flagged last.
- Sequences the transmitter byte by byte (start pulse, wait for done).
- A stalled requester is evicted after a timeout.

Parameters:
- NUM_REQ, 4, number of requesters (1..8).
- TIMEOUT, 1000000, cycles a granted requester may hold req_valid low mid-packet before eviction; 0 disables eviction.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  requester i has a byte on its lane
- req_byte  in  8*NUM_REQ  byte for requester i on bits [8i+7:8i]
- req_last  in  NUM_REQ  byte on lane i is the final byte of its packet
- req_ready  out  NUM_REQ  one-cycle pulse: lane i byte consumed
- grant  out  NUM_REQ  one-hot current owner; all zero when idle
- tx_start  out  1  one-cycle pulse to transmitter: send tx_byte
- tx_byte  out  8  byte to transmit, stable from tx_start until tx_done
- tx_busy  in  1  transmitter currently shifting
- tx_done  in  1  one-cycle pulse when stop bit completes
- err_timeout  out  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
- Reset: clk and rst are as stated above; rst is synchronous and active-high. Under rst, state=IDLE; grant=0, req_ready=0, tx_start=0, tx_byte=0x00, err_timeout=0. Internal last_grant=NUM_REQ-1, so requester 0 wins first. Timeout counter=0, last flag=0. Asserting rst mid-packet aborts the packet. The arbiter does not reset the transmitter; any byte already in flight completes on the line and its tx_done is ignored.
- All outputs are registered.
- States:
  - IDLE: if any req_valid, select the first set bit scanning from (last_grant+1) mod NUM_REQ upward with wrap-around. Register grant one-hot and go to ISSUE. Otherwise stay.
  - ISSUE: let g be the owner.
    - If req_valid[g]=1 and tx_busy=0: next cycle tx_start=1, tx_byte=req_byte[g], req_ready[g]=1 (all exactly one cycle); latch last flag=req_last[g]; clear the timeout counter; go to WAIT.
    - If req_valid[g]=1 and tx_busy=1: hold; the timeout counter does not advance.
    - If req_valid[g]=0: increment the timeout counter. When it reaches TIMEOUT (TIMEOUT>0), next cycle grant=0 and err_timeout=1 for one cycle; last_grant=g; go to IDLE.
  - WAIT: hold grant and tx_byte, wait for tx_done.
    - On tx_done with last flag=1: last_grant=g, grant=0 next cycle, go to IDLE.
    - On tx_done with last flag=0: go to ISSUE.
    - WAIT has no timeout.
- Latency: req_valid[i] rising in IDLE at cycle 0 with the transmitter free gives grant[i]=1 at cycle 1, and tx_start and req_ready[i] at cycle 2. After tx_done of a non-last byte at cycle t, the next tx_start is at t+2 if the byte is valid.
- Other requesters' req_valid is ignored while a grant is held; their req_ready stays 0.
- Simultaneous events:
  - tx_done with last in the same cycle as new requests: release first. Arbitration happens in the following IDLE cycle, using the updated last_grant.
  - req_valid[g] dropping in the same cycle the timeout would expire: the timeout is taken only if req_valid[g]=0 in that cycle.
- Single-byte packets: req_last=1 on the first byte; the grant is released after its tx_done.
- NUM_REQ=1: round-robin degenerates to always granting lane 0.
- Timeout counter width is $clog2(TIMEOUT+1), minimum 1.
- Requester contract: req_byte and req_last stay stable while req_valid is high until req_ready.

Test Plan:
- Single requester: lane 2 sends packet 0x41,0x42(last); TX model with tx_done 10 cycles after tx_start -> tx_byte sequence 0x41 then 0x42, two req_ready[2] pulses, grant=4'b0100 throughout, grant=0 after the second tx_done.
- Round-robin after reset: lanes 0,1,3 all request 1-byte packets continuously -> grant order 0,1,3,0,1,3; lane 2 is never granted.
- Packet lock: lane 1 owns a 3-byte packet while lane 0 requests -> all three lane-1 bytes are sent contiguously before lane 0 is granted; req_ready[0] stays 0 meanwhile.
- Back-pressure: tx_busy held high for 50 cycles in ISSUE -> no tx_start, no req_ready, no timeout; tx_start occurs 1 cycle after tx_busy falls.
- Timeout: TIMEOUT=16; lane 3 sends a non-last byte then drops req_valid -> err_timeout pulses exactly once, 17 cycles after entering ISSUE with valid low; grant clears; a pending lane 0 is granted next.
- Reset mid-packet: rst asserted during WAIT of byte 2 of 4 -> the next cycle shows all outputs at reset values; the stale tx_done is ignored; lane 0 has first priority afterwards.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ requesters.
// A granted requester keeps the line until its last byte completes or it stalls past TIMEOUT.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1000000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_byte_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 tx_start_o,
  output logic [7:0]           tx_byte_o,
  input  logic                 tx_busy_i,
  input  logic                 tx_done_i,
  output logic                 err_timeout_o
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNTW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNTW-1:0] CNT_LIMIT = CNTW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IDXW-1:0]     owner_q, owner_d;
  logic [IDXW-1:0]     lastGrant_q, lastGrant_d;
  logic [NUM_REQ-1:0]  ready_q, ready_d;
  logic                start_q, start_d;
  logic [7:0]          txByte_q, txByte_d;
  logic                err_q, err_d;
  logic                lastFlag_q, lastFlag_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;

  logic                pickValid;
  logic [IDXW-1:0]     pickIdx;
  logic [IDXW-1:0]     scanIdx;
  logic [7:0]          ownerByte;

  assign ownerByte = req_byte_i[{owner_q, 3'b000} +: 8];

  // Scan upward from the lane after the previous owner so every lane gets a fair turn.
  always_comb begin
    pickValid = 1'b0;
    pickIdx   = '0;
    scanIdx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scanIdx = IDXW'((int'(lastGrant_q) + k) % NUM_REQ);
      if (!pickValid && req_valid_i[scanIdx]) begin
        pickValid = 1'b1;
        pickIdx   = scanIdx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    lastGrant_d = lastGrant_q;
    ready_d     = '0;
    start_d     = 1'b0;
    txByte_d    = txByte_q;
    err_d       = 1'b0;
    lastFlag_d  = lastFlag_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pickValid) begin
          grant_d          = '0;
          grant_d[pickIdx] = 1'b1;
          owner_d          = pickIdx;
          cnt_d            = '0;
          state_d          = ISSUE;
        end
      end
      ISSUE: begin
        if (req_valid_i[owner_q]) begin
          if (!tx_busy_i) begin
            start_d          = 1'b1;
            txByte_d         = ownerByte;
            ready_d[owner_q] = 1'b1;
            lastFlag_d       = req_last_i[owner_q];
            cnt_d            = '0;
            state_d          = WAIT;
          end
        end else if (TIMEOUT > 0) begin
          // Eviction needs the lane to still be idle in the cycle the limit is reached.
          if (cnt_q == CNT_LIMIT) begin
            grant_d     = '0;
            err_d       = 1'b1;
            lastGrant_d = owner_q;
            cnt_d       = '0;
            state_d     = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WAIT: begin
        if (tx_done_i) begin
          if (lastFlag_q) begin
            grant_d     = '0;
            lastGrant_d = owner_q;
            state_d     = IDLE;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      lastGrant_q <= IDXW'(NUM_REQ - 1);
      ready_q     <= '0;
      start_q     <= 1'b0;
      txByte_q    <= 8'h00;
      err_q       <= 1'b0;
      lastFlag_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      lastGrant_q <= lastGrant_d;
      ready_q     <= ready_d;
      start_q     <= start_d;
      txByte_q    <= txByte_d;
      err_q       <= err_d;
      lastFlag_q  <= lastFlag_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready_o   = ready_q;
  assign grant_o       = grant_q;
  assign tx_start_o    = start_q;
  assign tx_byte_o     = txByte_q;
  assign err_timeout_o = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural transmitter that finishes
// each byte 10 cycles after its start pulse.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  reqValid = '0;
  logic [31:0] reqByte = '0;
  logic [3:0]  reqLast = '0;
  logic [3:0]  reqReady;
  logic [3:0]  grant;
  logic        txStart;
  logic [7:0]  txByte;
  logic        errTimeout;
  logic        txBusy;
  logic        txDone = 1'b0;
  logic        modelBusy = 1'b0;
  logic        forceBusy = 1'b0;
  int          modelCnt = 0;
  int          assertions = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(reqValid), .req_byte_i(reqByte),
    .req_last_i(reqLast), .req_ready_o(reqReady), .grant_o(grant),
    .tx_start_o(txStart), .tx_byte_o(txByte), .tx_busy_i(txBusy),
    .tx_done_i(txDone), .err_timeout_o(errTimeout)
  );

  // Transmitter model: busy from the start pulse, done pulse 10 cycles later.
  always @(posedge clk) begin
    #1;
    txDone = 1'b0;
    if (txStart) begin
      modelCnt  = 10;
      modelBusy = 1'b1;
    end else if (modelCnt > 0) begin
      modelCnt = modelCnt - 1;
      if (modelCnt == 0) begin
        txDone    = 1'b1;
        modelBusy = 1'b0;
      end
    end
  end

  assign txBusy = modelBusy | forceBusy;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((grant !== 4'b0000 || modelBusy) && n < 100) begin
      step();
      n++;
    end
    assertions++;
    if (grant !== 4'b0000 || modelBusy) begin
      failures++;
      $display("[TB] FAIL %s_idle: grant=%b busy=%b, required idle", name, grant, modelBusy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    assertions++;
    if (grant !== 4'b0000) begin failures++; $display("[TB] FAIL reset_grant: got %b need 0000", grant); end
    assertions++;
    if (reqReady !== 4'b0000) begin failures++; $display("[TB] FAIL reset_ready: got %b need 0000", reqReady); end
    assertions++;
    if (txStart !== 1'b0) begin failures++; $display("[TB] FAIL reset_start: got %b need 0", txStart); end
    assertions++;
    if (txByte !== 8'h00) begin failures++; $display("[TB] FAIL reset_byte: got %h need 00", txByte); end
    assertions++;
    if (errTimeout !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %b need 0", errTimeout); end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    reqByte[23:16] = 8'h41; reqLast[2] = 1'b0; reqValid[2] = 1'b1;
    step();
    assertions++;
    if (grant !== 4'b0100) begin failures++; $display("[TB] FAIL single_grant: got %b need 0100", grant); end
    step();
    assertions++;
    if (txStart !== 1'b1 || txByte !== 8'h41) begin failures++; $display("[TB] FAIL single_start1: start=%b byte=%h need 1/41", txStart, txByte); end
    assertions++;
    if (reqReady !== 4'b0100) begin failures++; $display("[TB] FAIL single_ready1: got %b need 0100", reqReady); end
    reqByte[23:16] = 8'h42; reqLast[2] = 1'b1;
    repeat (11) step();
    assertions++;
    if (txStart !== 1'b0 || grant !== 4'b0100) begin failures++; $display("[TB] FAIL single_hold: start=%b grant=%b need 0/0100", txStart, grant); end
    step();
    assertions++;
    if (txStart !== 1'b1 || txByte !== 8'h42) begin failures++; $display("[TB] FAIL single_start2: start=%b byte=%h need 1/42", txStart, txByte); end
    assertions++;
    if (reqReady !== 4'b0100) begin failures++; $display("[TB] FAIL single_ready2: got %b need 0100", reqReady); end
    reqValid[2] = 1'b0;
    repeat (10) step();
    assertions++;
    if (grant !== 4'b0100) begin failures++; $display("[TB] FAIL single_held_wait: got %b need 0100", grant); end
    step();
    assertions++;
    if (grant !== 4'b0000) begin failures++; $display("[TB] FAIL single_release: got %b need 0000", grant); end
  endtask

  task automatic test_round_robin();
    int order[6] = '{-1, -1, -1, -1, -1, -1};
    int expOrder[6] = '{0, 1, 3, 0, 1, 3};
    int starts = 0;
    int n = 0;
    int lane2Seen = 0;
    int byteErr = 0;
    int idx;
    rst = 1'b1;
    step();
    rst = 1'b0;
    reqByte = 32'hA3A2A1A0; reqLast = 4'b1111; reqValid = 4'b1011;
    while (starts < 6 && n < 200) begin
      step();
      n++;
      if (grant[2]) lane2Seen++;
      if (txStart) begin
        idx = -1;
        for (int b = 0; b < 4; b++) if (grant[b]) idx = b;
        order[starts] = idx;
        if (txByte !== 8'hA0 + 8'(idx)) byteErr++;
        starts++;
      end
    end
    reqValid = 4'b0000;
    assertions++;
    if (starts != 6) begin failures++; $display("[TB] FAIL rr_starts: got %0d need 6", starts); end
    for (int i = 0; i < 6; i++) begin
      assertions++;
      if (order[i] != expOrder[i]) begin failures++; $display("[TB] FAIL rr_order[%0d]: got %0d need %0d", i, order[i], expOrder[i]); end
    end
    assertions++;
    if (lane2Seen != 0) begin failures++; $display("[TB] FAIL rr_lane2: granted %0d cycles need 0", lane2Seen); end
    assertions++;
    if (byteErr != 0) begin failures++; $display("[TB] FAIL rr_bytes: %0d wrong bytes need 0", byteErr); end
    wait_idle("rr");
  endtask

  task automatic test_packet_lock();
    int lanes[4] = '{-1, -1, -1, -1};
    logic [7:0] bytes[4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    int expLanes[4] = '{1, 1, 1, 0};
    logic [7:0] expBytes[4] = '{8'h11, 8'h12, 8'h13, 8'h05};
    int starts = 0;
    int n = 0;
    int lane1Sent = 0;
    int early = 0;
    reqByte[15:8] = 8'h11; reqLast[1] = 1'b0; reqValid[1] = 1'b1;
    do begin step(); n++; end while (grant !== 4'b0010 && n < 20);
    assertions++;
    if (grant !== 4'b0010) begin failures++; $display("[TB] FAIL lock_grant1: got %b need 0010", grant); end
    reqByte[7:0] = 8'h05; reqLast[0] = 1'b1; reqValid[0] = 1'b1;
    n = 0;
    while (starts < 4 && n < 200) begin
      step();
      n++;
      if (txStart) begin
        for (int b = 0; b < 4; b++) if (grant[b]) lanes[starts] = b;
        bytes[starts] = txByte;
        starts++;
      end
      if (reqReady[0] && lane1Sent < 3) early++;
      if (reqReady[0]) reqValid[0] = 1'b0;
      if (reqReady[1]) begin
        lane1Sent++;
        reqByte[15:8] = 8'h11 + 8'(lane1Sent);
        reqLast[1] = (lane1Sent == 2);
        if (lane1Sent == 3) reqValid[1] = 1'b0;
      end
    end
    reqValid = 4'b0000;
    assertions++;
    if (starts != 4) begin failures++; $display("[TB] FAIL lock_starts: got %0d need 4", starts); end
    for (int i = 0; i < 4; i++) begin
      assertions++;
      if (lanes[i] != expLanes[i] || bytes[i] !== expBytes[i]) begin
        failures++;
        $display("[TB] FAIL lock_seq[%0d]: lane %0d byte %h need lane %0d byte %h", i, lanes[i], bytes[i], expLanes[i], expBytes[i]);
      end
    end
    assertions++;
    if (early != 0) begin failures++; $display("[TB] FAIL lock_ready0: %0d early pulses need 0", early); end
    wait_idle("lock");
  endtask

  task automatic test_back_pressure();
    int viol = 0;
    forceBusy = 1'b1;
    reqByte[23:16] = 8'h77; reqLast[2] = 1'b1; reqValid[2] = 1'b1;
    step();
    assertions++;
    if (grant !== 4'b0100) begin failures++; $display("[TB] FAIL bp_grant: got %b need 0100", grant); end
    repeat (50) begin
      step();
      if (txStart || reqReady !== 4'b0000 || errTimeout) viol++;
    end
    assertions++;
    if (viol != 0) begin failures++; $display("[TB] FAIL bp_hold: %0d active cycles need 0", viol); end
    forceBusy = 1'b0;
    step();
    assertions++;
    if (txStart !== 1'b1 || txByte !== 8'h77 || reqReady !== 4'b0100) begin
      failures++;
      $display("[TB] FAIL bp_release: start=%b byte=%h ready=%b need 1/77/0100", txStart, txByte, reqReady);
    end
    reqValid[2] = 1'b0;
    wait_idle("bp");
  endtask

  task automatic test_timeout();
    int n = 0;
    int errFirst = -1;
    int errCount = 0;
    logic [3:0] g18 = 4'bxxxx;
    logic [3:0] g19 = 4'bxxxx;
    reqByte[31:24] = 8'h33; reqLast[3] = 1'b0;
    reqByte[7:0] = 8'h0A; reqLast[0] = 1'b1;
    reqValid = 4'b1001;
    do begin step(); n++; end while (!reqReady[3] && n < 20);
    assertions++;
    if (!reqReady[3] || grant !== 4'b1000) begin failures++; $display("[TB] FAIL to_first: ready=%b grant=%b need 1000/1000", reqReady, grant); end
    reqValid[3] = 1'b0;
    n = 0;
    do begin step(); n++; end while (!txDone && n < 30);
    assertions++;
    if (!txDone) begin failures++; $display("[TB] FAIL to_done: got 0 need 1"); end
    for (int c = 1; c <= 25; c++) begin
      step();
      if (errTimeout) begin
        errCount++;
        if (errFirst < 0) errFirst = c;
      end
      if (c == 18) g18 = grant;
      if (c == 19) g19 = grant;
    end
    assertions++;
    if (errFirst != 18) begin failures++; $display("[TB] FAIL to_cycle: got %0d need 18", errFirst); end
    assertions++;
    if (errCount != 1) begin failures++; $display("[TB] FAIL to_count: got %0d need 1", errCount); end
    assertions++;
    if (g18 !== 4'b0000) begin failures++; $display("[TB] FAIL to_revoke: got %b need 0000", g18); end
    assertions++;
    if (g19 !== 4'b0001) begin failures++; $display("[TB] FAIL to_next: got %b need 0001", g19); end
    n = 0;
    while (!reqReady[0] && n < 30) begin step(); n++; end
    reqValid = 4'b0000;
    wait_idle("to");
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int sent = 0;
    logic prevBusy = 1'b1;
    reqByte[23:16] = 8'hC1; reqLast[2] = 1'b0; reqValid[2] = 1'b1;
    while (sent < 2 && n < 100) begin
      step();
      n++;
      if (reqReady[2]) begin
        sent++;
        reqByte[23:16] = 8'hC1 + 8'(sent);
      end
    end
    repeat (3) step();
    rst = 1'b1;
    reqValid = 4'b0101;
    reqByte[7:0] = 8'h50; reqLast[0] = 1'b1;
    reqByte[23:16] = 8'hC1; reqLast[2] = 1'b0;
    step();
    assertions++;
    if (grant !== 4'b0000 || reqReady !== 4'b0000 || txStart !== 1'b0 || txByte !== 8'h00 || errTimeout !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rstmid_outputs: grant=%b ready=%b start=%b byte=%h err=%b need all zero", grant, reqReady, txStart, txByte, errTimeout);
    end
    rst = 1'b0;
    step();
    assertions++;
    if (grant !== 4'b0001) begin failures++; $display("[TB] FAIL rstmid_priority: got %b need 0001", grant); end
    n = 0;
    while (!txStart && n < 30) begin
      prevBusy = modelBusy;
      step();
      n++;
    end
    assertions++;
    if (txStart !== 1'b1 || txByte !== 8'h50 || grant !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL rstmid_start: start=%b byte=%h grant=%b need 1/50/0001", txStart, txByte, grant);
    end
    assertions++;
    if (prevBusy !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_busy: started with busy=%b need 0", prevBusy); end
    reqValid = 4'b0000;
    wait_idle("rstmid");
  endtask

  initial begin
    $display("[TB] starting uart_tx_arbiter bench");
    test_reset();
    test_single();
    wait_idle("single");
    test_round_robin();
    test_packet_lock();
    test_back_pressure();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
